// File: rtl/modadd_pkg.sv
// Shared definitions for the modular-add arbiter: control FSM states and
// default sizing constants.
package modadd_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_NUM_REQ    = 4;

    // RUN: normal arbitration; DRAIN: wait for the pipeline to empty before a
    // modulus change; LOAD: one-cycle modulus write.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } state_e;

endpackage

// File: rtl/modadd_core.sv
// Combinational modular adder: result = (a + b) mod m, assuming a, b < m.
module modadd_core
    import modadd_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] m,
    output logic [DATA_WIDTH-1:0] result
);

    logic [DATA_WIDTH:0] sum_s;

    // Full-width sum keeps the carry so 254 + 254 against 255 is not lost;
    // the subtraction only needs the low bits because the true difference
    // always fits in DATA_WIDTH when both operands are below the modulus.
    always_comb begin
        sum_s = {1'b0, a} + {1'b0, b};
        if (sum_s >= {1'b0, m}) begin
            result = sum_s[DATA_WIDTH-1:0] - m;
        end else begin
            result = sum_s[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/modadd_arbiter.sv
// Round-robin arbiter feeding a two-stage modular-add pipeline, with a
// drain-then-load protocol for changing the modulus.
module modadd_arbiter
    import modadd_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REQ    = DEFAULT_NUM_REQ,
    parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    input  logic                          cfg_valid,
    input  logic [DATA_WIDTH-1:0]         cfg_modulus,
    output logic                          cfg_ready,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]               rsp_id
);

    // One extra bit so (last_grant + 1 + i) never overflows before wrapping.
    localparam int              IDX_W       = ID_W + 1;
    localparam logic [IDX_W-1:0] NUM_REQ_IDX = IDX_W'(NUM_REQ);
    localparam logic [ID_W-1:0]  LAST_ID     = ID_W'(NUM_REQ - 1);

    state_e                  state_q, state_d;
    logic [ID_W-1:0]         last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0]   mod_q, mod_d;

    logic                    s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0]   s1_a_q, s1_a_d;
    logic [DATA_WIDTH-1:0]   s1_b_q, s1_b_d;
    logic [ID_W-1:0]         s1_id_q, s1_id_d;

    logic                    s2_valid_q, s2_valid_d;
    logic [DATA_WIDTH-1:0]   s2_data_q, s2_data_d;
    logic [ID_W-1:0]         s2_id_q, s2_id_d;

    logic                    grant_en_s;
    logic                    cfg_ready_s;
    logic                    s2_free_s;
    logic                    s1_move_s;
    logic                    s1_open_s;
    logic                    accept_s;
    logic                    pick_found_s;
    logic                    hit_s;
    logic [ID_W-1:0]         pick_id_s;
    logic [IDX_W-1:0]        cand_s;
    logic [NUM_REQ-1:0]      grant_s;
    logic [DATA_WIDTH-1:0]   pick_a_s;
    logic [DATA_WIDTH-1:0]   pick_b_s;
    logic [DATA_WIDTH-1:0]   core_result_s;

    modadd_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .a      (s1_a_q),
        .b      (s1_b_q),
        .m      (mod_q),
        .result (core_result_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a modulus request drains the pipeline before loading;
    // dropping the request while draining abandons it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                state_d = cfg_valid ? DRAIN : RUN;
            end
            DRAIN: begin
                if (!cfg_valid) begin
                    state_d = RUN;
                end else if (!s1_valid_q && !s2_valid_q) begin
                    state_d = LOAD;
                end else begin
                    state_d = DRAIN;
                end
            end
            LOAD: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // FSM outputs: grants only in RUN with no pending modulus change.
    always_comb begin
        grant_en_s  = 1'b0;
        cfg_ready_s = 1'b0;
        case (state_q)
            RUN: begin
                grant_en_s  = !cfg_valid;
                cfg_ready_s = 1'b0;
            end
            DRAIN: begin
                grant_en_s  = 1'b0;
                cfg_ready_s = 1'b0;
            end
            LOAD: begin
                grant_en_s  = 1'b0;
                cfg_ready_s = !rst;
            end
            default: begin
                grant_en_s  = 1'b0;
                cfg_ready_s = 1'b0;
            end
        endcase
    end

    // Round-robin search starting one past the last accepted requester.
    always_comb begin
        pick_found_s = 1'b0;
        pick_id_s    = '0;
        cand_s       = '0;
        hit_s        = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s       = {1'b0, last_grant_q} + IDX_W'(1) + IDX_W'(i);
            cand_s       = (cand_s >= NUM_REQ_IDX) ? (cand_s - NUM_REQ_IDX) : cand_s;
            hit_s        = !pick_found_s && req_valid[cand_s[ID_W-1:0]];
            pick_id_s    = hit_s ? cand_s[ID_W-1:0] : pick_id_s;
            pick_found_s = pick_found_s | hit_s;
        end
    end

    // Pipeline occupancy, accept decision, one-hot grant and operand select.
    always_comb begin
        s2_free_s = !s2_valid_q || rsp_ready;
        s1_move_s = s1_valid_q && s2_free_s;
        s1_open_s = !s1_valid_q || s2_free_s;
        accept_s  = grant_en_s && s1_open_s && pick_found_s && !rst;
        grant_s   = '0;
        pick_a_s  = '0;
        pick_b_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_s[i] = accept_s && (pick_id_s == ID_W'(i));
            pick_a_s   = (pick_id_s == ID_W'(i)) ? req_a[i*DATA_WIDTH +: DATA_WIDTH] : pick_a_s;
            pick_b_s   = (pick_id_s == ID_W'(i)) ? req_b[i*DATA_WIDTH +: DATA_WIDTH] : pick_b_s;
        end
    end

    // Next-state for pipeline stages, grant pointer and modulus register.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_id_d    = s2_id_q;
        if (s2_free_s) begin
            s2_valid_d = s1_valid_q;
            s2_data_d  = s1_valid_q ? core_result_s : s2_data_q;
            s2_id_d    = s1_valid_q ? s1_id_q : s2_id_q;
        end else begin
            s2_valid_d = s2_valid_q;
        end

        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_id_d    = s1_id_q;
        if (accept_s) begin
            s1_valid_d = 1'b1;
            s1_a_d     = pick_a_s;
            s1_b_d     = pick_b_s;
            s1_id_d    = pick_id_s;
        end else if (s1_move_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        last_grant_d = accept_s ? pick_id_s : last_grant_q;
        mod_d        = (cfg_ready_s && cfg_valid) ? cfg_modulus : mod_q;
    end

    // Datapath and control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= LAST_ID;
            mod_q        <= '1;
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_id_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_id_q      <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            mod_q        <= mod_d;
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_id_q      <= s1_id_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            s2_id_q      <= s2_id_d;
        end
    end

    assign req_ready = grant_s;
    assign cfg_ready = cfg_ready_s;
    assign rsp_valid = s2_valid_q;
    assign rsp_data  = s2_data_q;
    assign rsp_id    = s2_id_q;

endmodule

// File: tb/tb_modadd_arbiter.sv
// Self-checking bench for modadd_arbiter: directed scenarios plus random
// traffic, checked against a queue-based model of accepted requests.
module tb_modadd_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*DW-1:0] req_a;
    logic [NR*DW-1:0] req_b;
    logic             cfg_valid;
    logic [DW-1:0]    cfg_modulus;
    logic             cfg_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [DW-1:0]    rsp_data;
    logic [IW-1:0]    rsp_id;

    always #5 clk = ~clk;

    modadd_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .ID_W       (IW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .cfg_valid   (cfg_valid),
        .cfg_modulus (cfg_modulus),
        .cfg_ready   (cfg_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_id      (rsp_id)
    );

    int checks   = 0;
    int failures = 0;

    int model_mod;
    int model_last;
    int q_data[$];
    int q_id[$];
    int grant_log[$];
    int rsp_count    = 0;
    int accept_count = 0;
    int cfg_pulses   = 0;
    int last_rsp_data;
    int last_rsp_id;
    bit prev_stall;
    int prev_data;
    int prev_id;
    logic [NR-1:0] last_ready_obs;
    int a_v[NR];
    int b_v[NR];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first valid requester after the previous winner.
    function automatic int rr_pick(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (v[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_reset();
        model_mod  = 255;
        model_last = NR - 1;
        q_data.delete();
        q_id.delete();
        prev_stall = 1'b0;
    endtask

    task automatic drive_ops();
        for (int i = 0; i < NR; i++) begin
            req_a[i*DW +: DW] = a_v[i][DW-1:0];
            req_b[i*DW +: DW] = b_v[i][DW-1:0];
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NR; i++) begin
            a_v[i] = int'($urandom % model_mod);
            b_v[i] = int'($urandom % model_mod);
        end
        drive_ops();
    endtask

    // One clock: observe and check outputs mid-cycle, then advance the model.
    task automatic cycle();
        int gid;
        bit was_rst;
        #1;
        was_rst        = rst;
        last_ready_obs = req_ready;
        if (rst) begin
            chk("rst_req_ready", int'(req_ready), 0);
            chk("rst_cfg_ready", int'(cfg_ready), 0);
        end else begin
            chk("inflight_max2", int'(q_data.size() <= 2), 1);
            chk("ready_onehot0", int'($countones(req_ready) <= 1), 1);
            chk("ready_without_valid", int'(req_ready & ~req_valid), 0);
            if (cfg_valid) chk("grant_during_cfg", int'(req_ready), 0);
            if (cfg_ready) begin
                chk("cfg_after_drain", q_data.size(), 0);
                if (cfg_valid) begin
                    model_mod = int'(cfg_modulus);
                    cfg_pulses++;
                end
            end
            if (prev_stall) begin
                chk("stall_valid", int'(rsp_valid), 1);
                chk("stall_data", int'(rsp_data), prev_data);
                chk("stall_id", int'(rsp_id), prev_id);
            end
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected_pending", int'(q_data.size() > 0), 1);
                if (q_data.size() > 0) begin
                    chk("rsp_data", int'(rsp_data), q_data.pop_front());
                    chk("rsp_id", int'(rsp_id), q_id.pop_front());
                end
                rsp_count++;
                last_rsp_data = int'(rsp_data);
                last_rsp_id   = int'(rsp_id);
            end
            if (req_ready != '0) begin
                gid = 0;
                for (int i = 0; i < NR; i++) if (req_ready[i]) gid = i;
                chk("rr_grant", gid, rr_pick(req_valid, model_last));
                model_last = gid;
                q_data.push_back((int'(req_a[gid*DW +: DW]) + int'(req_b[gid*DW +: DW])) % model_mod);
                q_id.push_back(gid);
                grant_log.push_back(gid);
                accept_count++;
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_data  = int'(rsp_data);
            prev_id    = int'(rsp_id);
        end
        @(posedge clk);
        #1;
        if (was_rst) model_reset();
    endtask

    task automatic set_mod(input int m);
        int n0;
        n0          = cfg_pulses;
        req_valid   = '0;
        rsp_ready   = 1'b1;
        cfg_valid   = 1'b1;
        cfg_modulus = m[DW-1:0];
        for (int k = 0; k < 40 && cfg_pulses == n0; k++) cycle();
        chk("cfg_handshake", cfg_pulses - n0, 1);
        cfg_valid = 1'b0;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 40 && q_data.size() > 0; k++) cycle();
        chk("drain_empty", q_data.size(), 0);
    endtask

    task automatic send_one(input int id, input int a, input int b);
        int n0;
        n0      = accept_count;
        a_v[id] = a;
        b_v[id] = b;
        drive_ops();
        req_valid     = '0;
        req_valid[id] = 1'b1;
        rsp_ready     = 1'b1;
        for (int k = 0; k < 20 && accept_count == n0; k++) cycle();
        chk("send_accepted", accept_count - n0, 1);
        drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int r0, a0, c0;
        rst         = 1'b1;
        req_valid   = '0;
        req_a       = '0;
        req_b       = '0;
        cfg_valid   = 1'b0;
        cfg_modulus = '0;
        rsp_ready   = 1'b0;
        model_reset();
        for (int i = 0; i < NR; i++) begin a_v[i] = 0; b_v[i] = 0; end

        // Reset: no grants even with every requester asking.
        req_valid = '1;
        cycle();
        cycle();
        rst       = 1'b0;
        req_valid = '0;
        #1;
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_data", int'(rsp_data), 0);
        chk("reset_rsp_id", int'(rsp_id), 0);
        chk("reset_cfg_ready", int'(cfg_ready), 0);

        // 9 + 8 mod 17 = 0, two cycles after accept.
        set_mod(17);
        a_v[0] = 9; b_v[0] = 8;
        drive_ops();
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        cycle();
        chk("t033_accept", int'(last_ready_obs), 1);
        req_valid = '0;
        chk("t033_n1_not_valid", int'(rsp_valid), 0);
        cycle();
        chk("t033_n2_valid", int'(rsp_valid), 1);
        chk("t033_data", int'(rsp_data), 0);
        chk("t033_id", int'(rsp_id), 0);
        drain();

        // 254 + 254 mod 255 = 253: carry must survive.
        set_mod(255);
        a_v[0] = 254; b_v[0] = 254;
        drive_ops();
        req_valid = 4'b0001;
        cycle();
        req_valid = '0;
        cycle();
        chk("t034_valid", int'(rsp_valid), 1);
        chk("t034_data", int'(rsp_data), 253);
        drain();

        // Fresh reset, then all four requesting: strict rotation, full rate.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        grant_log.delete();
        r0        = rsp_count;
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rand_ops();
            req_valid = '1;
            cycle();
        end
        req_valid = '0;
        chk("t035_grant_count", grant_log.size(), 8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) chk("t035_grant_order", grant_log[i], i % NR);
        chk("t035_rsp_rate", rsp_count - r0, 6);
        cycle();
        cycle();
        chk("t035_rsp_total", rsp_count - r0, 8);
        drain();

        // Backpressure for five cycles under random traffic.
        r0 = rsp_count;
        a0 = accept_count;
        for (int k = 0; k < 20; k++) begin
            rand_ops();
            req_valid = 4'($urandom_range(1, 15));
            rsp_ready = (k >= 5 && k < 10) ? 1'b0 : 1'b1;
            cycle();
        end
        drain();
        chk("t036_no_loss", rsp_count - r0, accept_count - a0);

        // Modulus change with two results in flight.
        set_mod(17);
        a0 = accept_count;
        r0 = rsp_count;
        rsp_ready = 1'b0;
        a_v[0] = 16; b_v[0] = 16; a_v[1] = 10; b_v[1] = 9;
        drive_ops();
        req_valid = 4'b0011;
        for (int k = 0; k < 10 && accept_count - a0 < 2; k++) cycle();
        chk("t037_two_in_flight", q_data.size(), 2);
        a_v[0] = 10; b_v[0] = 5;
        drive_ops();
        req_valid   = 4'b0001;
        cfg_valid   = 1'b1;
        cfg_modulus = 8'd13;
        c0          = cfg_pulses;
        cycle();
        cycle();
        cycle();
        chk("t037_no_early_cfg", cfg_pulses - c0, 0);
        rsp_ready = 1'b1;
        for (int k = 0; k < 30 && accept_count - a0 < 3; k++) begin
            cycle();
            if (cfg_pulses != c0) cfg_valid = 1'b0;
        end
        req_valid = '0;
        cfg_valid = 1'b0;
        drain();
        chk("t037_cfg_once", cfg_pulses - c0, 1);
        chk("t037_rsp_count", rsp_count - r0, 3);
        chk("t037_new_result", last_rsp_data, 2);

        // Abandoned modulus change: 13 stays in force.
        c0        = cfg_pulses;
        rsp_ready = 1'b0;
        a_v[2] = 3; b_v[2] = 4;
        drive_ops();
        req_valid = 4'b0100;
        cycle();
        req_valid   = '0;
        cfg_valid   = 1'b1;
        cfg_modulus = 8'd5;
        cycle();
        cycle();
        cfg_valid = 1'b0;
        cycle();
        drain();
        chk("t024_no_write", cfg_pulses - c0, 0);
        send_one(1, 7, 4);
        chk("t024_old_mod_kept", last_rsp_data, 11);

        // Reset with both stages full.
        rsp_ready = 1'b0;
        rand_ops();
        req_valid = '1;
        cycle();
        cycle();
        cycle();
        chk("t038_full", q_data.size(), 2);
        rst = 1'b1;
        cycle();
        rst       = 1'b0;
        req_valid = '0;
        chk("t038_rsp_valid", int'(rsp_valid), 0);
        chk("t038_rsp_data", int'(rsp_data), 0);
        a_v[0] = 200; b_v[0] = 100;
        for (int i = 1; i < NR; i++) begin a_v[i] = 1; b_v[i] = 1; end
        drive_ops();
        req_valid = '1;
        rsp_ready = 1'b1;
        cycle();
        chk("t038_first_grant", int'(last_ready_obs), 1);
        req_valid = '0;
        cycle();
        chk("t038_mod255", int'(rsp_data), 45);
        drain();

        // Random traffic across several moduli.
        for (int blk = 0; blk < 4; blk++) begin
            set_mod(int'($urandom_range(1, 255)));
            for (int k = 0; k < 60; k++) begin
                rand_ops();
                req_valid = 4'($urandom);
                rsp_ready = ($urandom % 4) != 0;
                cycle();
            end
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
